eta_add_pipe: RTL and testbench
===============================

ETA_ADD_PIPE -- requirements
Module: eta_add_pipe

Interface
REQ-001 Parameter WIDTH, default 16: width of both input rows and of the result.
REQ-002 Parameter SPLIT, default 8: number of low bits added approximately; legal range 1 to WIDTH-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream compressor-tree rows are valid.
REQ-006 in_ready  output  1  block accepts rows this cycle.
REQ-007 row_a  input  WIDTH  first reduced row (sum row).
REQ-008 row_b  input  WIDTH  second reduced row (carry row).
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 result  output  WIDTH  approximate sum.
REQ-012 carry_out  output  1  carry out of the exact upper-part add.
REQ-013 approx_hit  output  1  the low part contained a bit position where both rows are 1 (approximation was applied).
REQ-014 hit_count  output  16  saturating count of accepted transactions with approx_hit set.
REQ-015 hit_clear  input  1  synchronous clear of hit_count.

Function
REQ-016 Input transfer occurs on in_valid & in_ready; output transfer occurs on out_valid & out_ready.
REQ-017 Upper part: result[WIDTH-1:SPLIT] and carry_out SHALL equal the exact sum row_a[WIDTH-1:SPLIT] + row_b[WIDTH-1:SPLIT], with carry-in 0.
REQ-018 Low part, scanned from bit SPLIT-1 down to bit 0: each bit is a^b until the first position where a=b=1; that bit and all lower bits SHALL be 1.
REQ-019 approx_hit SHALL be 1 iff |(row_a[SPLIT-1:0] & row_b[SPLIT-1:0]).
REQ-020 Pipeline is two stages: S1 registers the low-part result, approx_hit, and the upper operands; S2 registers the upper add and the full outputs.
REQ-021 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready is held 1.
REQ-022 Throughput SHALL be one transaction per cycle when out_ready is held 1.
REQ-023 S2 advances when S2 is empty or out_ready=1; S1 advances into S2 under the same condition.
REQ-024 in_ready = !S1_valid | S2_advance, with no combinational path from in_valid to in_ready.
REQ-025 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Order SHALL be preserved; no transaction is dropped or duplicated.
REQ-027 hit_count increments by 1 on each input transfer whose rows produce approx_hit=1, and saturates at 0xFFFF.
REQ-028 hit_clear has priority over increment: the count becomes 0 and a simultaneous hit is not counted.

Reset
REQ-029 On rst=1 at a clock edge: S1_valid=0, S2_valid=0, out_valid=0, result=0, carry_out=0, approx_hit=0, hit_count=0.
REQ-030 While rst=1, in_ready SHALL be 0; in_ready becomes 1 in the first cycle after rst is deasserted.
REQ-031 Reset mid-operation SHALL discard all in-flight transactions; none of them appears at the output after reset.

Verification
REQ-032 No approximation: row_a=0x0012, row_b=0x0021 -> 2 cycles later result=0x0033, carry_out=0, approx_hit=0, hit_count unchanged.
REQ-033 Approximation: row_a=0x0150, row_b=0x0230 -> result=0x037F (exact sum 0x0380), approx_hit=1, hit_count increments by 1.
REQ-034 Upper overflow: row_a=0xFF00, row_b=0x0100 -> result=0x0000, carry_out=1, approx_hit=0.
REQ-035 Backpressure: hold out_ready=0 and offer 3 back-to-back transactions -> first 2 accepted, in_ready=0 on the third, outputs stable; then raise out_ready -> all 3 results emerge in order with no gaps.
REQ-036 Reset mid-flight: assert rst with 2 transactions in flight -> out_valid=0 on the next cycle, hit_count=0, and no stale results afterwards.
REQ-037 Counter: preload hit_count to 0xFFFF with hits -> a further hit leaves it at 0xFFFF; hit_clear asserted together with a hit -> hit_count=0.

Source files
------------

// File: rtl/eta_add_pipe.sv
// Approximate adder for two compressor-tree rows: exact upper add, carry-free low part.
// Latency 2 cycles; in_ready drops only when both stages are full and out_ready is low.
module eta_add_pipe #(
    parameter int WIDTH = 16,
    parameter int SPLIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] row_a,
    input  logic [WIDTH-1:0] row_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             approx_hit,
    output logic [15:0]      hit_count,
    input  logic             hit_clear
);

    localparam int UW = WIDTH - SPLIT;

    // Stage 1 state
    logic             s1_vld_q, s1_vld_d;
    logic [SPLIT-1:0] s1_lo_q, s1_lo_d;
    logic             s1_hit_q, s1_hit_d;
    logic [UW-1:0]    s1_a_hi_q, s1_a_hi_d;
    logic [UW-1:0]    s1_b_hi_q, s1_b_hi_d;

    // Stage 2 state
    logic             s2_vld_q, s2_vld_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic             s2_cout_q, s2_cout_d;
    logic             s2_hit_q, s2_hit_d;

    logic [15:0]      hit_cnt_q, hit_cnt_d;

    logic             s2_adv;
    logic             in_fire;
    logic [SPLIT-1:0] lo_approx;
    logic             lo_hit;
    logic [UW:0]      hi_sum;

    // Scanning from the MSB of the low part: once a (1,1) pair is seen, every
    // bit from there down saturates to 1 instead of propagating a carry.
    always_comb begin
        logic found;
        found     = 1'b0;
        lo_approx = '0;
        for (int i = SPLIT - 1; i >= 0; i--) begin
            if (row_a[i] & row_b[i]) begin
                found = 1'b1;
            end
            lo_approx[i] = found | (row_a[i] ^ row_b[i]);
        end
    end

    assign lo_hit = |(row_a[SPLIT-1:0] & row_b[SPLIT-1:0]);

    assign s2_adv   = !s2_vld_q | out_ready;
    assign in_ready = !rst & (!s1_vld_q | s2_adv);
    assign in_fire  = in_valid & in_ready;

    assign hi_sum = {1'b0, s1_a_hi_q} + {1'b0, s1_b_hi_q};

    always_comb begin
        s1_vld_d  = s1_vld_q & !s2_adv;
        s1_lo_d   = s1_lo_q;
        s1_hit_d  = s1_hit_q;
        s1_a_hi_d = s1_a_hi_q;
        s1_b_hi_d = s1_b_hi_q;
        if (in_fire) begin
            s1_vld_d  = 1'b1;
            s1_lo_d   = lo_approx;
            s1_hit_d  = lo_hit;
            s1_a_hi_d = row_a[WIDTH-1:SPLIT];
            s1_b_hi_d = row_b[WIDTH-1:SPLIT];
        end
    end

    // Result registers only load real data, so a stalled output never moves.
    always_comb begin
        s2_vld_d  = s2_vld_q;
        s2_res_d  = s2_res_q;
        s2_cout_d = s2_cout_q;
        s2_hit_d  = s2_hit_q;
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_res_d  = {hi_sum[UW-1:0], s1_lo_q};
                s2_cout_d = hi_sum[UW];
                s2_hit_d  = s1_hit_q;
            end
        end
    end

    // Clear wins over a coincident hit; the count sticks at all-ones.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (hit_clear) begin
            hit_cnt_d = '0;
        end else if (in_fire && lo_hit && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_lo_q   <= '0;
            s1_hit_q  <= 1'b0;
            s1_a_hi_q <= '0;
            s1_b_hi_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_res_q  <= '0;
            s2_cout_q <= 1'b0;
            s2_hit_q  <= 1'b0;
            hit_cnt_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_lo_q   <= s1_lo_d;
            s1_hit_q  <= s1_hit_d;
            s1_a_hi_q <= s1_a_hi_d;
            s1_b_hi_q <= s1_b_hi_d;
            s2_vld_q  <= s2_vld_d;
            s2_res_q  <= s2_res_d;
            s2_cout_q <= s2_cout_d;
            s2_hit_q  <= s2_hit_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign out_valid  = s2_vld_q;
    assign result     = s2_res_q;
    assign carry_out  = s2_cout_q;
    assign approx_hit = s2_hit_q;
    assign hit_count  = hit_cnt_q;

endmodule

// File: tb/tb_eta_add_pipe.sv
// Bench for eta_add_pipe: directed spec vectors, backpressure, reset, counter and random traffic.
module tb_eta_add_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] row_a;
    logic [15:0] row_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        carry_out;
    logic        approx_hit;
    logic [15:0] hit_count;
    logic        hit_clear;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    eta_add_pipe #(.WIDTH(16), .SPLIT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_a     (row_a),
        .row_b     (row_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .approx_hit(approx_hit),
        .hit_count (hit_count),
        .hit_clear (hit_clear)
    );

    // Reference: {approx_hit, carry_out, result}. The low byte is a XOR b with every
    // bit at or below the highest (1,1) position forced to 1.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
        int hi;
        int lo;
        int j;
        hi = int'(a[15:8]) + int'(b[15:8]);
        j  = -1;
        for (int k = 0; k < 8; k++) begin
            if (a[k] && b[k]) j = k;
        end
        lo = int'(a[7:0] ^ b[7:0]);
        if (j >= 0) lo = lo | ((1 << (j + 1)) - 1);
        return {1'(j >= 0), 1'(hi >> 8), 8'(hi), 8'(lo)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; hit_clear = 1'b0;
        row_a = '0; row_b = '0;
        repeat (2) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_vec++; if (result !== 16'h0) begin n_err++; $display("FAIL rst_result got %h want 0000", result); end
        n_vec++; if (carry_out !== 1'b0) begin n_err++; $display("FAIL rst_carry got %b want 0", carry_out); end
        n_vec++; if (approx_hit !== 1'b0) begin n_err++; $display("FAIL rst_hit got %b want 0", approx_hit); end
        n_vec++; if (hit_count !== 16'h0) begin n_err++; $display("FAIL rst_count got %h want 0000", hit_count); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
    endtask

    task automatic test_vector(input logic [15:0] a, input logic [15:0] b, input logic [15:0] er,
                               input logic ec, input logic eh, input string name);
        logic [15:0] cnt0;
        @(negedge clk);
        cnt0 = hit_count;
        row_a = a; row_b = b; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_early got out_valid=%b want 0", name, out_valid); end
        n_vec++; if (hit_count !== 16'(cnt0 + 16'(eh))) begin n_err++; $display("FAIL %s_count got %h want %h", name, hit_count, 16'(cnt0 + 16'(eh))); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL %s_latency got out_valid=%b want 1", name, out_valid); end
        n_vec++; if ({approx_hit, carry_out, result} !== {eh, ec, er})
            begin n_err++; $display("FAIL %s_value got %b/%b/%h want %b/%b/%h", name, approx_hit, carry_out, result, eh, ec, er); end
    endtask

    task automatic test_backpressure();
        logic [15:0] a [3];
        logic [15:0] b [3];
        logic [17:0] e [3];
        for (int i = 0; i < 3; i++) begin
            a[i] = 16'($urandom); b[i] = 16'($urandom); e[i] = model(a[i], b[i]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; row_a = a[i]; row_b = b[i];
            #1;
            n_vec++; if (in_ready !== (i < 2)) begin n_err++; $display("FAIL bp_accept%0d got %b want %b", i, in_ready, (i < 2)); end
        end
        for (int s = 0; s < 3; s++) begin
            if (s > 0) begin @(negedge clk); #1; end
            n_vec++; if (out_valid !== 1'b1 || {approx_hit, carry_out, result} !== e[0] || in_ready !== 1'b0)
                begin n_err++; $display("FAIL bp_hold%0d got v=%b r=%b %h want v=1 r=0 %h", s, out_valid, in_ready, {approx_hit, carry_out, result}, e[0]); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(negedge clk); in_valid = 1'b0; #1; end
            n_vec++; if (out_valid !== 1'b1 || {approx_hit, carry_out, result} !== e[k])
                begin n_err++; $display("FAIL bp_drain%0d got v=%b %h want v=1 %h", k, out_valid, {approx_hit, carry_out, result}, e[k]); end
        end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; row_a = 16'h0101; row_b = 16'h0301;
        @(negedge clk);
        row_a = 16'h2244; row_b = 16'h1144;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
        n_vec++; if (hit_count !== 16'h0) begin n_err++; $display("FAIL mid_count got %h want 0000", hit_count); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready got %b want 0", in_ready); end
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale%0d got out_valid=%b want 0", i, out_valid); end
        end
    endtask

    task automatic test_counter();
        @(negedge clk);
        hit_clear = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        hit_clear = 1'b0;
        row_a = 16'h0001; row_b = 16'h0001; in_valid = 1'b1;
        repeat (65535) @(negedge clk);
        n_vec++; if (hit_count !== 16'hFFFF) begin n_err++; $display("FAIL cnt_fill got %h want ffff", hit_count); end
        @(negedge clk);
        n_vec++; if (hit_count !== 16'hFFFF) begin n_err++; $display("FAIL cnt_saturate got %h want ffff", hit_count); end
        hit_clear = 1'b1;
        @(negedge clk);
        hit_clear = 1'b0;
        n_vec++; if (hit_count !== 16'h0) begin n_err++; $display("FAIL cnt_clear_priority got %h want 0000", hit_count); end
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++; if (hit_count !== 16'h1) begin n_err++; $display("FAIL cnt_after_clear got %h want 0001", hit_count); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [17:0] q[$];
        logic [17:0] exp;
        logic [17:0] held;
        logic [15:0] cnt;
        logic        stall_prev;
        stall_prev = 1'b0;
        held = '0;
        @(negedge clk);
        hit_clear = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        hit_clear = 1'b0;
        cnt = '0;
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            n_vec++; if (hit_count !== cnt) begin n_err++; $display("FAIL rnd_count c=%0d got %h want %h", c, hit_count, cnt); end
            if (stall_prev) begin
                n_vec++; if (out_valid !== 1'b1 || {approx_hit, carry_out, result} !== held)
                    begin n_err++; $display("FAIL rnd_hold c=%0d got v=%b %h want v=1 %h", c, out_valid, {approx_hit, carry_out, result}, held); end
            end
            if (c < 400) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                hit_clear = ($urandom_range(0, 31) == 0);
                row_a     = 16'($urandom);
                row_b     = ($urandom_range(0, 3) == 0) ? {8'($urandom), ~row_a[7:0]} : 16'($urandom);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1; hit_clear = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rnd_spurious c=%0d got %h want nothing", c, {approx_hit, carry_out, result});
                end else begin
                    exp = q.pop_front();
                    if ({approx_hit, carry_out, result} !== exp)
                        begin n_err++; $display("FAIL rnd_value c=%0d got %h want %h", c, {approx_hit, carry_out, result}, exp); end
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {approx_hit, carry_out, result};
            exp = model(row_a, row_b);
            if (in_valid && in_ready) q.push_back(exp);
            if (hit_clear) cnt = '0;
            else if (in_valid && in_ready && exp[17] && cnt != 16'hFFFF) cnt = cnt + 16'd1;
        end
        n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL rnd_drain got %0d left want 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_vector(16'h0012, 16'h0021, 16'h0033, 1'b0, 1'b0, "no_approx");
        test_vector(16'h0150, 16'h0230, 16'h037F, 1'b0, 1'b1, "approx");
        test_vector(16'hFF00, 16'h0100, 16'h0000, 1'b1, 1'b0, "overflow");
        test_backpressure();
        test_reset_midflight();
        test_counter();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
